// File: rtl/frame_stream_sequencer.sv
// Streams one frame of bytes from a synchronous-read frame buffer to a byte transmitter,
// gated by a qualified frame-ready level, with inter-byte gap and post-frame cooldown.
module frame_stream_sequencer #(
  parameter int P_DATA_W          = 8,
  parameter int P_BYTES_PER_FRAME = 9216,
  parameter int P_ADDR_W          = 15,
  parameter int P_HOLDOFF_CLKS    = 62500000,
  parameter int P_GAP_CLKS        = 1085,
  parameter int P_COOLDOWN_CLKS   = 62500000,
  parameter int P_REARM_ON_EDGE   = 1
) (
  input  logic                Clk,
  input  logic                i_Rst,
  input  logic                i_VS,
  input  logic                i_Abort,
  output logic                o_Rd_En,
  output logic [P_ADDR_W-1:0] o_Rd_Addr,
  input  logic [P_DATA_W-1:0] i_Rd_Data,
  output logic [P_DATA_W-1:0] o_Tx_Data,
  output logic                o_Tx_Valid,
  input  logic                i_Tx_Ready,
  output logic                o_Frame_Indicator,
  output logic                o_Busy,
  output logic                o_Frame_Done,
  output logic [15:0]         o_Frame_Count
);

  localparam int MAX_HG  = (P_HOLDOFF_CLKS > P_GAP_CLKS) ? P_HOLDOFF_CLKS : P_GAP_CLKS;
  localparam int MAX_CNT = (MAX_HG > P_COOLDOWN_CLKS) ? MAX_HG : P_COOLDOWN_CLKS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam bit                HAS_GAP    = (P_GAP_CLKS > 32'sd0);
  localparam bit                REARM_EDGE = (P_REARM_ON_EDGE != 32'sd0);
  localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_BYTES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(P_HOLDOFF_CLKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(HAS_GAP ? (P_GAP_CLKS - 1) : 0);
  localparam logic [CNT_W-1:0]  COOL_LAST  = CNT_W'(P_COOLDOWN_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLDOFF  = 3'd1,
    ST_FETCH    = 3'd2,
    ST_LOAD     = 3'd3,
    ST_SEND     = 3'd4,
    ST_GAP      = 3'd5,
    ST_COOLDOWN = 3'd6
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  armed_r;
  logic                  rd_en_r;
  logic [P_ADDR_W-1:0]   rd_addr_r;
  logic [P_DATA_W-1:0]   tx_data_r;
  logic                  tx_valid_r;
  logic                  indicator_r;
  logic                  busy_r;
  logic                  done_r;
  logic [15:0]           frame_cnt_r;

  logic                  last_addr_s;
  logic                  xfer_s;
  logic                  armed_s;

  // Decode helpers shared by the sequencer branches.
  always_comb begin
    last_addr_s = (rd_addr_r == LAST_ADDR);
    xfer_s      = tx_valid_r && i_Tx_Ready;
    armed_s     = armed_r || !REARM_EDGE;
  end

  // Frame sequencer: state, counters and every registered output.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      armed_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      indicator_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else if (i_Abort && (state_r != ST_IDLE)) begin
      // Abort beats a simultaneous transfer, so that byte is never counted.
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      armed_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      tx_valid_r  <= 1'b0;
      indicator_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!i_VS) begin
            armed_r <= 1'b1;
          end
          if (armed_s && i_VS) begin
            state_r     <= ST_HOLDOFF;
            cnt_r       <= '0;
            indicator_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (!i_VS) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            indicator_r <= 1'b1;
            busy_r      <= 1'b0;
          end else if (cnt_r == HOLD_LAST) begin
            state_r   <= ST_FETCH;
            cnt_r     <= '0;
            rd_addr_r <= '0;
            rd_en_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_r  <= i_Rd_Data;
          tx_valid_r <= 1'b1;
          state_r    <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer_s) begin
            tx_valid_r <= 1'b0;
            if (last_addr_s) begin
              done_r      <= 1'b1;
              frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            cnt_r <= '0;
            if (HAS_GAP) begin
              state_r <= ST_GAP;
            end else if (last_addr_s) begin
              state_r <= ST_COOLDOWN;
            end else begin
              rd_addr_r <= rd_addr_r + P_ADDR_W'(1'b1);
              rd_en_r   <= 1'b1;
              state_r   <= ST_FETCH;
            end
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= '0;
            if (last_addr_s) begin
              state_r <= ST_COOLDOWN;
            end else begin
              rd_addr_r <= rd_addr_r + P_ADDR_W'(1'b1);
              rd_en_r   <= 1'b1;
              state_r   <= ST_FETCH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_COOLDOWN: begin
          if (cnt_r == COOL_LAST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            armed_r     <= 1'b0;
            rd_addr_r   <= '0;
            indicator_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          armed_r     <= 1'b0;
          rd_addr_r   <= '0;
          tx_valid_r  <= 1'b0;
          indicator_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rd_En           = rd_en_r;
  assign o_Rd_Addr         = rd_addr_r;
  assign o_Tx_Data         = tx_data_r;
  assign o_Tx_Valid        = tx_valid_r;
  assign o_Frame_Indicator = indicator_r;
  assign o_Busy            = busy_r;
  assign o_Frame_Done      = done_r;
  assign o_Frame_Count     = frame_cnt_r;

endmodule

// File: doc/frame_stream_sequencer.md
FRAME_STREAM_SEQUENCER -- requirements
Module: frame_stream_sequencer

Interface
REQ-001 Parameter P_DATA_W, 8: pixel/byte width.
REQ-002 Parameter P_BYTES_PER_FRAME, 9216: bytes streamed per frame, legal range 1..2^P_ADDR_W.
REQ-003 Parameter P_ADDR_W, 15: frame-buffer read address width.
REQ-004 Parameter P_HOLDOFF_CLKS, 62500000: cycles i_VS must stay high before streaming starts, legal range >=1.
REQ-005 Parameter P_GAP_CLKS, 1085: idle cycles inserted after each accepted byte, 0 = none.
REQ-006 Parameter P_COOLDOWN_CLKS, 62500000: cycles held in COOLDOWN after the last byte, legal range >=1.
REQ-007 Parameter P_REARM_ON_EDGE, 1: 1 = i_VS must be seen low in IDLE before the next frame; 0 = level-triggered.
REQ-008 Clk  in  1  sole clock, all logic on rising edge.
REQ-009 i_Rst  in  1  reset, synchronous, active-high.
REQ-010 i_VS  in  1  frame-ready qualifier, high = frame buffer complete.
REQ-011 i_Abort  in  1  synchronous abort of the current frame.
REQ-012 o_Rd_En  out  1  frame-buffer read strobe.
REQ-013 o_Rd_Addr  out  P_ADDR_W  frame-buffer read address.
REQ-014 i_Rd_Data  in  P_DATA_W  frame-buffer data, valid exactly 1 cycle after o_Rd_En.
REQ-015 o_Tx_Data  out  P_DATA_W  byte to transmitter.
REQ-016 o_Tx_Valid  out  1  o_Tx_Data valid.
REQ-017 i_Tx_Ready  in  1  transmitter accepts; a transfer occurs on a cycle with o_Tx_Valid=1 and i_Tx_Ready=1.
REQ-018 o_Frame_Indicator  out  1  high only in IDLE.
REQ-019 o_Busy  out  1  high in every state except IDLE.
REQ-020 o_Frame_Done  out  1  one-cycle pulse on the transfer of the last byte of a frame.
REQ-021 o_Frame_Count  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-022 States: IDLE, HOLDOFF, FETCH, LOAD, SEND, GAP, COOLDOWN; all outputs registered.
REQ-023 IDLE: with armed=1 and i_VS=1, go to HOLDOFF with the counter cleared; armed is set by i_VS=0 in IDLE, or is constant 1 when P_REARM_ON_EDGE=0.
REQ-024 HOLDOFF: counter increments while i_VS=1; i_VS=0 returns to IDLE; reaching P_HOLDOFF_CLKS consecutive high cycles goes to FETCH with address 0.
REQ-025 FETCH: o_Rd_En=1 for exactly one cycle with the current o_Rd_Addr, then LOAD.
REQ-026 LOAD: capture i_Rd_Data into o_Tx_Data, set o_Tx_Valid=1, then SEND.
REQ-027 SEND: hold o_Tx_Data and o_Tx_Valid stable until a transfer occurs; o_Tx_Valid clears on the cycle after the transfer.
REQ-028 After a transfer: if P_GAP_CLKS>0 go to GAP for exactly P_GAP_CLKS cycles, otherwise take the post-gap decision immediately.
REQ-029 Post-gap: if address = P_BYTES_PER_FRAME-1 go to COOLDOWN, else increment address and go to FETCH.
REQ-030 Exactly P_BYTES_PER_FRAME bytes per frame, addresses 0..P_BYTES_PER_FRAME-1 in order, no duplicates and no skips.
REQ-031 The last-byte transfer pulses o_Frame_Done and increments o_Frame_Count on that cycle.
REQ-032 COOLDOWN: P_COOLDOWN_CLKS cycles, then IDLE with armed cleared; i_VS is ignored in COOLDOWN.
REQ-033 i_VS falling during FETCH..GAP does not interrupt the frame.
REQ-034 i_Abort=1 in any non-IDLE state: next state IDLE, o_Tx_Valid=0, o_Rd_En=0, address 0, armed cleared, o_Frame_Count unchanged, no o_Frame_Done.
REQ-035 i_Abort takes precedence over a simultaneous transfer; that byte counts as not sent.
REQ-036 Counter width is sized for the largest of P_HOLDOFF_CLKS, P_GAP_CLKS and P_COOLDOWN_CLKS; counters never wrap.

Reset
REQ-037 i_Rst=1: state IDLE, o_Rd_En=0, o_Rd_Addr=0, o_Tx_Data=0, o_Tx_Valid=0, o_Frame_Indicator=1, o_Busy=0, o_Frame_Done=0, o_Frame_Count=0, armed=0, counters 0.
REQ-038 i_Rst has priority over i_Abort and all other inputs; reset asserted mid-frame drops o_Tx_Valid on the next edge.

Verification
REQ-039 Test parameters: BYTES=4, HOLDOFF=3, GAP=2, COOLDOWN=5, REARM=1.
REQ-040 Nominal: i_VS low then high, i_Tx_Ready=1, RAM[0..3]=A0..A3 -> bytes A0,A1,A2,A3 in order; 2 idle cycles between transfers; o_Frame_Done pulses once; o_Frame_Count=1.
REQ-041 Backpressure: i_Tx_Ready low for 7 cycles on byte 2 -> o_Tx_Valid and o_Tx_Data=A2 held stable for all 7 cycles; no byte lost or repeated.
REQ-042 Holdoff glitch: i_VS high for 2 cycles, low for 1, then high -> no o_Rd_En until 3 consecutive high cycles.
REQ-043 Rearm: i_VS held high across two frames -> second frame does not start until i_VS goes low in IDLE; with REARM=0 it restarts 3 cycles after reaching IDLE.
REQ-044 Abort/reset: i_Abort on the byte-2 transfer cycle -> IDLE next cycle, o_Frame_Count unchanged, next frame restarts at address 0; repeat with i_Rst -> all reset values of REQ-037.
